// File: rtl/dbus_gemm_responder_pkg.sv
// ============================================================================
// Module      : dbus_gemm_responder_pkg
// Description : Shared types and constants for the GEMM data-bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dbus_gemm_responder_pkg;

    localparam int SCRATCHPAD_DEPTH = 128;

    typedef struct packed {
        logic            en;
        logic            rdwr;      // 1 = write, 0 = read
        logic [3:0]      mask;
        logic [31:0]     addr;
        logic [3:0][7:0] wr_data;
        logic [3:0][7:0] rd_data;
    } dbus_interface;

    localparam logic [12:0] CTRL_OFS   = 13'h000;
    localparam logic [12:0] STATUS_OFS = 13'h004;
    localparam logic [12:0] DIM_OFS    = 13'h008;
    localparam logic [12:0] CYCLES_OFS = 13'h00C;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    typedef enum logic [0:0] {
        GEMM_IDLE = 1'b0,
        GEMM_RUN  = 1'b1
    } gemm_state_e;

endpackage

`default_nettype wire

// File: rtl/dbus_sp_ram.sv
// ============================================================================
// Module      : dbus_sp_ram
// Description : Scratchpad RAM, one byte-masked R/W port and one read port,
//               both with registered 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_sp_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_en,
    input  logic          i_a_we,
    input  logic [3:0]    i_a_mask,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic [31:0]   o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    output logic [31:0]   o_b_rdata
);

    logic [3:0][7:0] r_mem [DEPTH];
    logic [31:0]     r_a_rdata;
    logic [31:0]     r_b_rdata;

    // Storage is deliberately left unreset so contents survive a soft reset.
    always_ff @(posedge clk) begin
        if (i_a_en && i_a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_a_mask[i]) begin
                    r_mem[i_a_addr][i] <= i_a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rdata <= 32'd0;
            r_b_rdata <= 32'd0;
        end else begin
            if (i_a_en && !i_a_we) begin
                r_a_rdata <= r_mem[i_a_addr];
            end
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

`default_nettype wire

// File: rtl/dbus_gemm_responder.sv
// ============================================================================
// Module      : dbus_gemm_responder
// Description : dbus responder exposing GEMM control registers and a
//               byte-maskable scratchpad. GEMM_IRQ_EN adds the irq output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_gemm_responder
    import dbus_gemm_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SP_DEPTH  = SCRATCHPAD_DEPTH,
    parameter logic [31:0] SP_OFFSET = 32'h0000_1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  dbus_interface               dbus_req,
    output logic [3:0][7:0]             dbus_rd_data,
    output logic                        gemm_start,
    output logic [23:0]                 gemm_dim,
    input  logic                        gemm_done,
    input  logic [$clog2(SP_DEPTH)-1:0] acc_rd_addr,
    output logic [31:0]                 acc_rd_data
`ifdef GEMM_IRQ_EN
    ,
    output logic                        irq
`endif
);

    localparam int AW = $clog2(SP_DEPTH);

    gemm_state_e r_state;
    gemm_state_e w_state_next;
    logic        w_launch;
    logic        w_start_err;
    logic        w_done_set;

    logic        r_gemm_start;
    logic [23:0] r_dim;
    logic [31:0] r_cycles;
    logic        r_done;
    logic        r_err;
    logic        r_rd_sp;
    logic [31:0] r_reg_rdata;
    logic [31:0] w_reg_rdata;
    logic [31:0] w_sp_rdata;
    logic        w_ie;

    logic [31:0] w_wdata;
    logic [12:0] w_ofs;
    logic [12:0] w_ofs_word;
    logic [31:0] w_ofs_ext;
    logic        w_hit;
    logic        w_sp_hit;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_dim_wr;
    logic        w_start_req;
    logic        w_sp_drop;
    logic        w_unused;

    assign w_wdata     = dbus_req.wr_data;
    assign w_ofs       = dbus_req.addr[12:0];
    assign w_ofs_word  = {w_ofs[12:2], 2'b00};
    assign w_ofs_ext   = {19'd0, w_ofs};
    assign w_hit       = dbus_req.en && (dbus_req.addr[31:13] == BASE_ADDR[31:13]);
    assign w_sp_hit    = w_hit && (w_ofs_ext >= SP_OFFSET)
                         && (w_ofs_ext < SP_OFFSET + 32'(4 * SP_DEPTH));
    assign w_wr        = w_hit && dbus_req.rdwr;
    assign w_rd        = w_hit && !dbus_req.rdwr;
    assign w_busy      = (r_state == GEMM_RUN);
    assign w_ctrl_wr   = w_wr && !w_sp_hit && (w_ofs_word == CTRL_OFS);
    assign w_status_wr = w_wr && !w_sp_hit && (w_ofs_word == STATUS_OFS);
    assign w_dim_wr    = w_wr && !w_sp_hit && (w_ofs_word == DIM_OFS);
    assign w_start_req = w_ctrl_wr && w_wdata[CTRL_START_BIT];
    assign w_sp_drop   = w_sp_hit && dbus_req.rdwr && w_busy;
    assign w_unused    = ^{dbus_req.addr[1:0], dbus_req.rd_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GEMM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_start_err  = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            GEMM_IDLE: begin
                if (w_start_req) begin
                    w_state_next = GEMM_RUN;
                    w_launch     = 1'b1;
                end
            end
            GEMM_RUN: begin
                if (w_start_req) begin
                    w_start_err = 1'b1;
                end
                if (gemm_done) begin
                    w_state_next = GEMM_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = GEMM_IDLE;
        endcase
    end

    always_comb begin
        w_reg_rdata = 32'd0;
        if (w_rd && !w_sp_hit) begin
            case (w_ofs_word)
                CTRL_OFS: w_reg_rdata[CTRL_IE_BIT] = w_ie;
                STATUS_OFS: begin
                    w_reg_rdata[STATUS_BUSY_BIT] = w_busy;
                    w_reg_rdata[STATUS_DONE_BIT] = r_done;
                    w_reg_rdata[STATUS_ERR_BIT]  = r_err;
                end
                DIM_OFS:    w_reg_rdata = {8'd0, r_dim};
                CYCLES_OFS: w_reg_rdata = r_cycles;
                default:    w_reg_rdata = 32'd0;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gemm_start <= 1'b0;
            r_dim        <= 24'd0;
            r_cycles     <= 32'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rd_sp      <= 1'b0;
            r_reg_rdata  <= 32'd0;
        end else begin
            r_gemm_start <= w_launch;
            if (w_dim_wr) begin
                r_dim <= w_wdata[23:0];
            end
            if (w_launch) begin
                r_cycles <= 32'd0;
            end else if (w_busy && (r_cycles != 32'hFFFF_FFFF)) begin
                r_cycles <= r_cycles + 32'd1;
            end
            r_done  <= (r_done & ~(w_status_wr & w_wdata[STATUS_DONE_BIT])) | w_done_set;
            r_err   <= (r_err & ~(w_status_wr & w_wdata[STATUS_ERR_BIT]))
                       | w_start_err | w_sp_drop;
            r_rd_sp     <= w_rd && w_sp_hit;
            r_reg_rdata <= w_reg_rdata;
        end
    end

`ifdef GEMM_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ie <= w_wdata[CTRL_IE_BIT];
            end
            r_irq <= r_done & r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    dbus_sp_ram #(
        .DEPTH (SP_DEPTH),
        .AW    (AW)
    ) u_sp_ram (
        .clk       (clk),
        .rst       (rst),
        .i_a_en    (w_sp_hit && !w_sp_drop),
        .i_a_we    (dbus_req.rdwr),
        .i_a_mask  (dbus_req.mask),
        .i_a_addr  (dbus_req.addr[2 +: AW]),
        .i_a_wdata (w_wdata),
        .o_a_rdata (w_sp_rdata),
        .i_b_addr  (acc_rd_addr),
        .o_b_rdata (acc_rd_data)
    );

    assign dbus_rd_data = r_rd_sp ? w_sp_rdata : r_reg_rdata;
    assign gemm_start   = r_gemm_start;
    assign gemm_dim     = r_dim;

endmodule

`default_nettype wire

// File: tb/tb_dbus_gemm_responder.sv
// ============================================================================
// Module      : tb_dbus_gemm_responder
// Description : Directed self-checking bench for dbus_gemm_responder
//               (irq checks compiled in when GEMM_IRQ_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_gemm_responder;
    import dbus_gemm_responder_pkg::*;

    localparam logic [31:0] A_CTRL   = 32'h4000_0000;
    localparam logic [31:0] A_STATUS = 32'h4000_0004;
    localparam logic [31:0] A_DIM    = 32'h4000_0008;
    localparam logic [31:0] A_CYCLES = 32'h4000_000C;
    localparam logic [31:0] A_SP     = 32'h4000_1000;

    logic            clk = 1'b0;
    logic            rst;
    dbus_interface   req;
    logic [3:0][7:0] dbus_rd_data;
    logic            gemm_start;
    logic [23:0]     gemm_dim;
    logic            gemm_done;
    logic [6:0]      acc_rd_addr;
    logic [31:0]     acc_rd_data;
`ifdef GEMM_IRQ_EN
    logic            irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    logic [31:0] rd;

    dbus_gemm_responder dut (
        .clk          (clk),
        .rst          (rst),
        .dbus_req     (req),
        .dbus_rd_data (dbus_rd_data),
        .gemm_start   (gemm_start),
        .gemm_dim     (gemm_dim),
        .gemm_done    (gemm_done),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data)
`ifdef GEMM_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gemm_start) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        req.en = 1'b1; req.rdwr = 1'b1; req.addr = a; req.wr_data = d; req.mask = m;
        @(posedge clk); #1;
        req.en = 1'b0; req.rdwr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req.en = 1'b1; req.rdwr = 1'b0; req.addr = a; req.mask = 4'h0;
        @(posedge clk); #1;
        d = dbus_rd_data;
        req.en = 1'b0;
    endtask

    task automatic pulse_done();
        gemm_done = 1'b1;
        @(posedge clk); #1;
        gemm_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; gemm_done = 1'b0; acc_rd_addr = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_start", {31'd0, gemm_start}, 32'd0);
        check_eq("rst_dim", {8'd0, gemm_dim}, 32'd0);
        check_eq("rst_rdata", dbus_rd_data, 32'd0);
        rst = 1'b0;
        bus_read(A_STATUS, rd); check_eq("rst_status", rd, 32'd0);
        bus_read(A_CYCLES, rd); check_eq("rst_cycles", rd, 32'd0);

        // Byte-masked scratchpad writes
        bus_write(A_SP + 32'd20, 32'hDEAD_BEEF, 4'b1111);
        check_eq("wr_rdata_zero", dbus_rd_data, 32'd0);
        bus_write(A_SP + 32'd20, 32'h0000_00AA, 4'b0001);
        bus_read(A_SP + 32'd20, rd); check_eq("sp_w5", rd, 32'hDEAD_BEAA);
        bus_write(A_SP + 32'd24, 32'h1122_3344, 4'b1111);
        bus_write(A_SP + 32'd24, 32'hFFFF_FFFF, 4'b1010);
        bus_read(A_SP + 32'd24, rd); check_eq("sp_w6", rd, 32'hFF22_FF44);
        acc_rd_addr = 7'd5;
        @(posedge clk); #1;
        check_eq("acc_w5", acc_rd_data, 32'hDEAD_BEAA);

        // Run of exactly 20 cycles
        bus_write(A_DIM, 32'h0008_1010, 4'b1111);
        bus_read(A_DIM, rd); check_eq("dim_rd", rd, 32'h0008_1010);
        check_eq("gemm_dim", {8'd0, gemm_dim}, 32'h0008_1010);
        bus_write(A_CTRL, 32'd1, 4'b1111);
        check_eq("start_pulse", {31'd0, gemm_start}, 32'd1);
        bus_read(A_STATUS, rd); check_eq("status_busy", rd, 32'h1);
        check_eq("start_low", {31'd0, gemm_start}, 32'd0);
        repeat (18) @(posedge clk);
        #1;
        pulse_done();
        bus_read(A_STATUS, rd); check_eq("status_done", rd, 32'h2);
        bus_read(A_CYCLES, rd); check_eq("cycles_20", rd, 32'd20);
        bus_read(A_CTRL, rd); check_eq("ctrl_rd", rd, 32'd0);

        // START during RUN, ERR W1C
        bus_write(A_CTRL, 32'd1, 4'b1111);
        bus_write(A_CTRL, 32'd1, 4'b1111);
        bus_read(A_STATUS, rd); check_eq("status_err", rd, 32'h7);
        check_eq("start_cnt", start_cnt, 32'd2);
        bus_write(A_STATUS, 32'h4, 4'b1111);
        bus_read(A_STATUS, rd); check_eq("err_clr", rd, 32'h3);

        // Scratchpad write while busy is dropped
        bus_write(A_SP + 32'd20, 32'h1234_5678, 4'b1111);
        bus_read(A_SP + 32'd20, rd); check_eq("sp_busy_drop", rd, 32'hDEAD_BEAA);
        bus_read(A_STATUS, rd); check_eq("sp_busy_err", rd, 32'h7);
        bus_write(A_STATUS, 32'h6, 4'b1111);
        bus_read(A_STATUS, rd); check_eq("flags_clr", rd, 32'h1);

        // DONE set beats simultaneous W1C
        gemm_done = 1'b1;
        bus_write(A_STATUS, 32'h2, 4'b1111);
        gemm_done = 1'b0;
        bus_read(A_STATUS, rd); check_eq("done_set_wins", rd, 32'h2);
        bus_read(32'h4000_0010, rd); check_eq("unmapped", rd, 32'd0);
        bus_read(32'h5000_1014, rd); check_eq("miss", rd, 32'd0);
        bus_read(A_SP + 32'h200, rd); check_eq("sp_past_end", rd, 32'd0);

        // Reset in the middle of a run
        bus_write(A_CTRL, 32'd1, 4'b1111);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_run_start", {31'd0, gemm_start}, 32'd0);
        check_eq("rst_run_dim", {8'd0, gemm_dim}, 32'd0);
        bus_read(A_STATUS, rd); check_eq("rst_run_status", rd, 32'd0);
        bus_read(A_CYCLES, rd); check_eq("rst_run_cycles", rd, 32'd0);
        bus_read(A_SP + 32'd20, rd); check_eq("rst_ram_kept", rd, 32'hDEAD_BEAA);

`ifdef GEMM_IRQ_EN
        bus_write(A_CTRL, 32'd3, 4'b1111);
        bus_read(A_CTRL, rd); check_eq("ie_rd", rd, 32'h2);
        pulse_done();
        @(posedge clk); #1;
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        bus_write(A_STATUS, 32'h2, 4'b1111);
        @(posedge clk); #1;
        check_eq("irq_clr", {31'd0, irq}, 32'd0);
`else
        bus_write(A_CTRL, 32'd2, 4'b1111);
        bus_read(A_CTRL, rd); check_eq("ie_absent", rd, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dbus_gemm_responder.md
Name: dbus_gemm_responder

Overview:
- Data-bus responder on the accelerator side of the core's dbus_interface struct.
- Decodes CPU loads and stores into two regions: a small control/status register file for the GEMM accelerator, and a byte-maskable scratchpad RAM.
- The RAM's second read port feeds the systolic-array loader.
- Launches GEMM runs, tracks busy/done, and measures run length in cycles.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of responder address window (addr[31:13] compared).
- SP_DEPTH, Config::SCRATCHPAD_DEPTH (128), scratchpad depth in 32-bit words.
- SP_OFFSET, 32'h0000_1000, offset of scratchpad window within BASE_ADDR region.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dbus_req  in  dbus_interface  CPU request; en, rdwr (1=write, 0=read), mask, wr_data and addr are used; rd_data field ignored
- dbus_rd_data  out  [3:0][7:0]  read response, valid exactly 1 cycle after a read request
- gemm_start  out  1  one-cycle launch pulse to accelerator
- gemm_dim  out  24  {N[23:16], K[15:8], M[7:0]} from DIM register
- gemm_done  in  1  single-cycle completion pulse from accelerator
- acc_rd_addr  in  $clog2(SP_DEPTH)  accelerator scratchpad read address
- acc_rd_data  out  32  accelerator read data, 1-cycle latency

Behaviour:
- Hit: en=1 and addr[31:13]==BASE_ADDR[31:13]. addr[1:0] ignored (word access only).
- Register map (offset = addr[12:0]):
  - 0x000 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IE.
  - 0x004 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C).
  - 0x008 DIM: RW, bits[23:0].
  - 0x00C CYCLES: RO.
- Scratchpad region: SP_OFFSET .. SP_OFFSET+4*SP_DEPTH-1, word index = addr[2+:$clog2(SP_DEPTH)].
- Writes:
  - Scratchpad: byte lane i written when mask[i]=1.
  - Registers: mask ignored, full 32-bit write.
- Reads: dbus_rd_data registered, 1-cycle latency for both regions.
- Unmapped, miss or write cycles: dbus_rd_data returns 0 on the next cycle.
- FSM states:
  - IDLE -> RUN on START write; gemm_start=1 that same following cycle, CYCLES cleared to 0, DONE unaffected.
  - RUN -> IDLE on gemm_done=1; DONE set.
  - START write while in RUN: ignored, ERR set.
  - gemm_done while in IDLE: ignored.
- CYCLES: increments by 1 each cycle in RUN, saturates at 32'hFFFF_FFFF, holds in IDLE.
- BUSY = (state==RUN).
- Scratchpad writes while BUSY are dropped and set ERR. Reads while BUSY are permitted.
- Simultaneous events:
  - W1C of DONE in the cycle gemm_done arrives: set wins.
  - W1C of ERR in the same cycle as a new error: set wins.
- Reset: state IDLE, all outputs 0, CTRL/STATUS/DIM/CYCLES = 0. Reset mid-RUN aborts to IDLE with no DONE. RAM contents not reset.
- acc_rd_data: registered read of acc_rd_addr every cycle, independent of dbus.

Optional Feature:
- GEMM_IRQ_EN defined:
  - Adds output port irq (1 bit), irq = DONE & IE, registered.
  - Reset 0; drops the cycle after DONE is cleared.
- GEMM_IRQ_EN undefined:
  - No irq port; IE bit reads 0 and is not writable.

Decomposition:
- Config package additions:
  - Register offsets CTRL_OFS/STATUS_OFS/DIM_OFS/CYCLES_OFS.
  - STATUS bit-position constants.
  - typedef enum gemm_state_e {GEMM_IDLE, GEMM_RUN}.
- Sub-module dbus_sp_ram: SP_DEPTH x 32 RAM with one byte-masked read/write port and one read-only port, both registered, 1-cycle latency.

Test Plan:
- Write 0xDEADBEEF mask 4'b1111 to SP word 5, then write 0x000000AA mask 4'b0001 to word 5, read word 5 -> dbus_rd_data=0xDEADBEAA one cycle later; acc_rd_addr=5 -> acc_rd_data=0xDEADBEAA.
- Write DIM=0x081010, write CTRL=1 -> gemm_start one pulse, gemm_dim=0x081010, STATUS=0x1; gemm_done after 20 cycles -> STATUS=0x2, CYCLES=20.
- START while RUN -> no second gemm_start, STATUS bit2 set; write STATUS=0x4 -> ERR cleared, BUSY still 1.
- SP write during RUN -> RAM word unchanged on readback, ERR=1.
- W1C STATUS=0x2 in the same cycle as gemm_done -> DONE stays 1. Read of unmapped offset 0x010 -> 0.
- rst asserted mid-RUN -> BUSY=0, DONE=0, gemm_start=0, CYCLES=0; previously written SP word still reads back. With GEMM_IRQ_EN: IE=1 plus done -> irq=1, W1C DONE -> irq=0 next cycle.
